demap_rd_arbiter: RTL and testbench

- Shares the demapper read port (column select and read strobe) between two requesters: the channel estimator (est) and the equalizer (eq).
- Grants whole bursts: one requester owns the port until it signals done, then a drain gap runs before the next grant.
- Tags returning read data with its owner so each requester sees only its own valid strobe.
- Sits between the demapper RE buffer and the ch_est / equalizer control units.

---
 rtl/demap_rd_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_demap_rd_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demap_rd_arbiter.sv
// demap_rd_arbiter: shares the demapper read port between the channel
// estimator (est) and the equalizer (eq). The port is granted for whole
// bursts. Each burst is followed by an RD_LAT-cycle drain, and returning
// data is tagged with the requester that issued the read.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a grant is revoked
// after MAX_HOLD cycles and a sticky err_timeout flag is raised.
module demap_rd_arbiter #(
  parameter int unsigned COL_W    = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_est,
  input  logic [COL_W-1:0] col_est,
  input  logic             rd_est,
  input  logic             done_est,
  output logic             gnt_est,
  output logic             rvalid_est,
  input  logic             req_eq,
  input  logic [COL_W-1:0] col_eq,
  input  logic             rd_eq,
  input  logic             done_eq,
  output logic             gnt_eq,
  output logic             rvalid_eq,
  output logic [COL_W-1:0] demap_col,
  output logic             demap_read,
  output logic             busy,
  output logic             err_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_G_EST = 2'd1;
  localparam logic [1:0] S_G_EQ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic OWN_EST = 1'b0;
  localparam logic OWN_EQ  = 1'b1;

  localparam int unsigned DRAIN_W = 3;

  // Reject parameter values outside the supported range at elaboration
  if (RD_LAT < 1 || RD_LAT > 4 || MAX_HOLD < 1) begin : g_bad_param
    $error("demap_rd_arbiter: RD_LAT must be 1..4 and MAX_HOLD must be >= 1");
  end

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               last_gnt;
  logic               last_gnt_nxt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] drain_cnt_nxt;
  logic               own_end;
  logic               hold_expired;
  logic [RD_LAT-1:0]  pipe_est;
  logic [RD_LAT-1:0]  pipe_eq;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic              in_grant;
  logic [HOLD_W-1:0] hold_cnt;
  logic              err_q;

  assign in_grant     = (state == S_G_EST) || (state == S_G_EQ);
  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign err_timeout  = err_q;

  // Count cycles the current grant has been held; latch a forced revoke
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (in_grant) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (in_grant && hold_expired && !own_end) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign hold_expired = 1'b0;
  assign err_timeout  = 1'b0;
`endif

  // State register: FSM state, round-robin pointer, drain counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_gnt  <= OWN_EQ;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last_gnt  <= last_gnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state logic: arbitration in IDLE, burst end in G_x, drain countdown
  always_comb begin
    state_nxt     = state;
    last_gnt_nxt  = last_gnt;
    drain_cnt_nxt = drain_cnt;
    own_end       = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_est && (!req_eq || (last_gnt == OWN_EQ))) begin
          state_nxt = S_G_EST;
        end else if (req_eq) begin
          state_nxt = S_G_EQ;
        end
      end
      S_G_EST: begin
        own_end = done_est | ~req_est;
        if (own_end || hold_expired) begin
          state_nxt     = S_DRAIN;
          last_gnt_nxt  = OWN_EST;
          drain_cnt_nxt = DRAIN_W'(RD_LAT - 1);
        end
      end
      S_G_EQ: begin
        own_end = done_eq | ~req_eq;
        if (own_end || hold_expired) begin
          state_nxt     = S_DRAIN;
          last_gnt_nxt  = OWN_EQ;
          drain_cnt_nxt = DRAIN_W'(RD_LAT - 1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          drain_cnt_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read port mux: only the granted requester reaches the demapper
  always_comb begin
    demap_read = 1'b0;
    demap_col  = '0;
    case (state)
      S_G_EST: begin
        demap_read = rd_est;
        demap_col  = col_est;
      end
      S_G_EQ: begin
        demap_read = rd_eq;
        demap_col  = col_eq;
      end
      default: begin
        demap_read = 1'b0;
        demap_col  = '0;
      end
    endcase
  end

  // Registered grant/busy flags and per-owner read-return pipelines
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_est  <= 1'b0;
      gnt_eq   <= 1'b0;
      busy     <= 1'b0;
      pipe_est <= '0;
      pipe_eq  <= '0;
    end else begin
      gnt_est  <= (state_nxt == S_G_EST);
      gnt_eq   <= (state_nxt == S_G_EQ);
      busy     <= (state_nxt != S_IDLE);
      pipe_est <= RD_LAT'({pipe_est, demap_read & (state == S_G_EST)});
      pipe_eq  <= RD_LAT'({pipe_eq, demap_read & (state == S_G_EQ)});
    end
  end

  assign rvalid_est = pipe_est[RD_LAT-1];
  assign rvalid_eq  = pipe_eq[RD_LAT-1];

endmodule

// File: tb/tb_demap_rd_arbiter.sv
// Testbench for demap_rd_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_demap_rd_arbiter;

  localparam int unsigned COL_W    = 4;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             req_est, rd_est, done_est;
  logic [COL_W-1:0] col_est;
  logic             req_eq, rd_eq, done_eq;
  logic [COL_W-1:0] col_eq;
  logic             gnt_est, rvalid_est, gnt_eq, rvalid_eq;
  logic [COL_W-1:0] demap_col;
  logic             demap_read, busy, err_timeout;

  demap_rd_arbiter #(
    .COL_W   (COL_W),
    .RD_LAT  (RD_LAT),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_est    (req_est),
    .col_est    (col_est),
    .rd_est     (rd_est),
    .done_est   (done_est),
    .gnt_est    (gnt_est),
    .rvalid_est (rvalid_est),
    .req_eq     (req_eq),
    .col_eq     (col_eq),
    .rd_eq      (rd_eq),
    .done_eq    (done_eq),
    .gnt_eq     (gnt_eq),
    .rvalid_eq  (rvalid_eq),
    .demap_col  (demap_col),
    .demap_read (demap_read),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // {gnt_est, gnt_eq, rvalid_est, rvalid_eq, demap_read, busy, err_timeout, demap_col}
  logic [10:0] act;
  assign act = {gnt_est, gnt_eq, rvalid_est, rvalid_eq, demap_read, busy, err_timeout, demap_col};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       req_est;
    logic [3:0] col_est;
    logic       rd_est;
    logic       done_est;
    logic       req_eq;
    logic [3:0] col_eq;
    logic       rd_eq;
    logic       done_eq;
    logic [10:0] exp;
  } vec_t;

  vec_t tab[$];

  function automatic logic [10:0] ex(bit ge, bit gq, bit ve, bit vq, bit rd, bit bz, logic [3:0] col);
    return {ge, gq, ve, vq, rd, bz, 1'b0, col};
  endfunction

  function automatic vec_t row(bit r, bit qe, logic [3:0] ce, bit re, bit de,
                               bit qq, logic [3:0] cq, bit rq, bit dq, logic [10:0] x);
    vec_t v;
    v.rst = r; v.req_est = qe; v.col_est = ce; v.rd_est = re; v.done_est = de;
    v.req_eq = qq; v.col_eq = cq; v.rd_eq = rq; v.done_eq = dq; v.exp = x;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; req_est = v.req_est; col_est = v.col_est; rd_est = v.rd_est; done_est = v.done_est;
    req_eq = v.req_eq; col_eq = v.col_eq; rd_eq = v.rd_eq; done_eq = v.done_eq;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; req_est = 1'b0; col_est = '0; rd_est = 1'b0; done_est = 1'b0;
    req_eq = 1'b0; col_eq = '0; rd_eq = 1'b0; done_eq = 1'b0;
  endtask

  task automatic check_vec(input string name, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Wait (bounded) for the selected grant; returns with time just after a negedge
  task automatic wait_gnt(input bit for_eq, input int lim, output bit got);
    got = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(negedge clk); #1;
      if (for_eq ? gnt_eq : gnt_est) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_int(name, int'(ok), 1);
  endtask

  // Behavioural model state
  int holder;   // 0 none, 1 est, 2 eq
  int gap;      // drain cycles still to run
  int last;     // 1 est, 2 eq
  int held;     // grant cycles so far
  bit m_err;
  int rq[$];    // owner of each read in flight, oldest first

  task automatic model_reset();
    holder = 0; gap = 0; last = 2; held = 0; m_err = 1'b0;
    rq = {};
    for (int i = 0; i < int'(RD_LAT); i++) rq.push_back(0);
  endtask

  function automatic logic [10:0] model_out();
    bit rd;
    logic [3:0] col;
    rd  = (holder == 1) ? rd_est : (holder == 2) ? rd_eq : 1'b0;
    col = (holder == 1) ? col_est : (holder == 2) ? col_eq : 4'd0;
    return {holder == 1, holder == 2, rq[0] == 1, rq[0] == 2, rd,
            (holder != 0) || (gap != 0), m_err, col};
  endfunction

  task automatic model_step();
    bit rd;
    bit fin;
    if (rst) begin
      model_reset();
    end else begin
      rd = (holder == 1) ? rd_est : (holder == 2) ? rd_eq : 1'b0;
      void'(rq.pop_front());
      rq.push_back(rd ? holder : 0);
      if (holder != 0) begin
        fin = (holder == 1) ? (done_est || !req_est) : (done_eq || !req_eq);
        held++;
        if (fin || (TO_EN && held == int'(MAX_HOLD))) begin
          if (!fin) m_err = 1'b1;
          last = holder; holder = 0; gap = RD_LAT;
        end
      end else if (gap > 0) begin
        gap--;
      end else if (req_est && (!req_eq || last == 2)) begin
        holder = 1; held = 0;
      end else if (req_eq) begin
        holder = 2; held = 0;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  order[6];
  int  bursts, hold, both, n;
  bit  got, ok;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single est burst, then simultaneous requests from reset with stray eq signals
    tab.push_back(row(0, 1,0,0,0, 0,0,0,0, ex(0,0,0,0,0,0,0)));
    tab.push_back(row(0, 1,0,0,0, 0,0,0,0, ex(1,0,0,0,0,1,0)));
    tab.push_back(row(0, 1,3,1,0, 0,0,0,0, ex(1,0,0,0,1,1,3)));
    tab.push_back(row(0, 1,4,1,0, 0,0,0,0, ex(1,0,1,0,1,1,4)));
    tab.push_back(row(0, 1,5,1,1, 0,0,0,0, ex(1,0,1,0,1,1,5)));
    tab.push_back(row(0, 0,0,0,0, 0,0,0,0, ex(0,0,1,0,0,1,0)));
    tab.push_back(row(0, 0,0,0,0, 0,0,0,0, ex(0,0,0,0,0,0,0)));
    tab.push_back(row(1, 0,0,0,0, 0,0,0,0, ex(0,0,0,0,0,0,0)));
    tab.push_back(row(0, 1,0,0,0, 1,0,0,0, ex(0,0,0,0,0,0,0)));
    tab.push_back(row(0, 1,7,1,0, 1,9,1,0, ex(1,0,0,0,1,1,7)));
    tab.push_back(row(0, 1,2,0,0, 1,9,1,1, ex(1,0,1,0,0,1,2)));
    tab.push_back(row(0, 1,1,1,1, 1,9,1,0, ex(1,0,0,0,1,1,1)));
    tab.push_back(row(0, 0,0,0,0, 1,0,0,0, ex(0,0,1,0,0,1,0)));
    tab.push_back(row(0, 0,0,0,0, 1,0,0,0, ex(0,0,0,0,0,0,0)));
    tab.push_back(row(0, 0,0,0,0, 1,6,1,0, ex(0,1,0,0,1,1,6)));
    tab.push_back(row(0, 0,0,0,0, 1,0,0,1, ex(0,1,0,1,0,1,0)));
    tab.push_back(row(0, 0,0,0,0, 0,0,0,0, ex(0,0,0,0,0,1,0)));
    tab.push_back(row(0, 0,0,0,0, 0,0,0,0, ex(0,0,0,0,0,0,0)));

    foreach (tab[i]) begin
      @(negedge clk);
      apply(tab[i]);
      #1;
      check_vec($sformatf("vec%0d", i), act, tab[i].exp);
    end

    // Round-robin: both request continuously, each burst ends after 3 grant cycles
    bursts = 0; hold = 0; both = 0;
    foreach (order[i]) order[i] = 0;
    @(negedge clk);
    idle_inputs();
    req_est = 1'b1; req_eq = 1'b1;
    for (int c = 0; c < 300 && bursts < 6; c++) begin
      @(negedge clk);
      done_est = 1'b0; done_eq = 1'b0;
      #1;
      if (gnt_est && gnt_eq) both++;
      if (gnt_est || gnt_eq) begin
        if (hold == 0) order[bursts] = gnt_est ? 1 : 2;
        hold++;
        if (hold == 3) begin
          if (gnt_est) done_est = 1'b1; else done_eq = 1'b1;
          bursts++;
          hold = 0;
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    check_int("rr_bursts", bursts, 6);
    check_int("rr_both_granted", both, 0);
    foreach (order[i]) check_int($sformatf("rr_order%0d", i), order[i], (i % 2 == 0) ? 1 : 2);
    wait_idle("rr_idle");

    // Abort: req_est dropped mid-burst without done
    @(negedge clk);
    req_est = 1'b1;
    wait_gnt(1'b0, 10, got);
    check_int("abort_gnt", int'(got), 1);
    rd_est = 1'b1; col_est = 4'd2;
    @(negedge clk);
    rd_est = 1'b0; col_est = '0; req_est = 1'b0;
    #1;
    check_int("abort_gnt_held", int'(gnt_est), 1);
    n = 0; ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (busy && !gnt_est && !gnt_eq && !demap_read && demap_col == '0) n++;
      else begin
        ok = (act == 11'd0);
        break;
      end
    end
    check_int("abort_drain_cycles", n, int'(RD_LAT));
    check_int("abort_idle_after", int'(ok), 1);

    // Reset with a read in flight
    @(negedge clk);
    req_est = 1'b1;
    wait_gnt(1'b0, 10, got);
    check_int("rst_gnt", int'(got), 1);
    rd_est = 1'b1; col_est = 4'd5; rst = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    check_vec("rst_inflight", act, 11'd0);
    @(negedge clk); #1;
    check_vec("rst_no_rvalid", act, 11'd0);

`ifdef ARB_TIMEOUT_EN
    // Timeout: est never sends done, eq waits
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_est = 1'b1; req_eq = 1'b1;
    wait_gnt(1'b0, 10, got);
    check_int("to_gnt_est", int'(got), 1);
    n = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (gnt_est) n++; else break;
    end
    req_est = 1'b0;
    check_int("to_hold_cycles", n, int'(MAX_HOLD));
    check_int("to_err_set", int'(err_timeout), 1);
    wait_gnt(1'b1, 10, got);
    check_int("to_gnt_eq", int'(got), 1);
    done_eq = 1'b1;
    @(negedge clk);
    idle_inputs();
    wait_idle("to_idle");
    check_int("to_err_sticky", int'(err_timeout), 1);
`else
    // Without timeout a grant is held indefinitely
    @(negedge clk);
    req_est = 1'b1;
    wait_gnt(1'b0, 10, got);
    check_int("hold_gnt", int'(got), 1);
    repeat (20) @(negedge clk);
    #1;
    check_int("hold_still_granted", int'(gnt_est), 1);
    check_int("hold_no_err", int'(err_timeout), 0);
    @(negedge clk);
    idle_inputs();
    wait_idle("hold_idle");
`endif

    // Randomized traffic against the behavioural model
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 249) == 0);
      req_est  = ($urandom_range(0, 7) != 0);
      req_eq   = ($urandom_range(0, 7) != 0);
      done_est = ($urandom_range(0, 5) == 0);
      done_eq  = ($urandom_range(0, 5) == 0);
      rd_est   = 1'($urandom_range(0, 1));
      rd_eq    = 1'($urandom_range(0, 1));
      col_est  = 4'($urandom_range(0, 15));
      col_eq   = 4'($urandom_range(0, 15));
      #1;
      check_vec($sformatf("rand%0d", c), act, model_out());
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
